// File: rtl/lbuf_dma_scheduler_pkg.sv
// Shared FSM encodings, geometry defaults and sizing helper for the linebuffer DMA scheduler.
// No logic; latency and backpressure are properties of the modules that import it.
// States are plain localparams so legacy code can compare against raw encodings.
package lbuf_dma_scheduler_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_ACTIVE = 2'd1;
  localparam fsm_state_t ST_DRAIN  = 2'd2;

  localparam int DEF_WORDS_PER_LINE  = 480;
  localparam int DEF_LINES_PER_FRAME = 1080;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lbuf_bank_ring.sv
// Bank ring: write/read pointers, occupancy and the line number held in each filled bank.
// Latency: push/pop take effect at the next pclk edge; read-side tag follows the read pointer.
// Backpressure: caller only pushes when not full or popping in the same cycle, and pops when non-empty.
module lbuf_bank_ring
  import lbuf_dma_scheduler_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int LINE_W    = 12,
  parameter int PTR_W     = clog2(NUM_BANKS)
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [LINE_W-1:0] push_tag,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [PTR_W:0]    occupancy,
  output logic [PTR_W:0]    occ_nxt,
  output logic [LINE_W-1:0] rd_tag,
  output logic              empty,
  output logic              full
);

  logic [LINE_W-1:0] tags [NUM_BANKS];

  assign empty  = (occupancy == '0);
  assign full   = (occupancy == (PTR_W+1)'(NUM_BANKS));
  assign rd_tag = tags[rd_ptr];

  // Simultaneous push and pop leaves occupancy unchanged, which is what lets a full ring accept.
  always_comb begin
    occ_nxt = occupancy;
    if (clear)
      occ_nxt = '0;
    else if (push && !pop)
      occ_nxt = occupancy + 1'b1;
    else if (pop && !push)
      occ_nxt = occupancy - 1'b1;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < NUM_BANKS; i++) tags[i] <= '0;
    end else begin
      occupancy <= occ_nxt;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          tags[wr_ptr] <= push_tag;
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbuf_dma_scheduler.sv
// Linebuffer bank scheduler between pixel capture and PS DMA; frame FSM, irqs, overflow; LBUF_STATS_EN adds drop/peak stats.
// Latency: line_end -> line_irq/dma_req one cycle; last drain ack -> frame_irq one cycle once in DRAIN.
// Backpressure: wr_enable drops when all banks are filled; a line_end with no free bank is dropped and flagged.
module lbuf_dma_scheduler
  import lbuf_dma_scheduler_pkg::*;
#(
  parameter int NUM_BANKS       = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int LINE_W          = 12
) (
  input  logic                     pclk,
  input  logic                     reset_n,
  input  logic                     vsync,
  input  logic                     line_end,
  output logic                     wr_enable,
  output logic [ADDRESS_WIDTH-1:0] wr_base,
  output logic                     dma_req,
  output logic [ADDRESS_WIDTH-1:0] dma_base,
  output logic [LINE_W-1:0]        dma_line,
  input  logic                     dma_ack,
  output logic                     line_irq,
  output logic                     frame_irq,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [3:0]               max_occ
);

  localparam int                PTR_W     = clog2(NUM_BANKS);
  localparam logic [PTR_W:0]    OCC_FULL  = (PTR_W+1)'(NUM_BANKS);
  localparam logic [PTR_W:0]    OCC_ONE   = (PTR_W+1)'(1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME);

  fsm_state_t        state;
  fsm_state_t        state_nxt;
  logic              vsync_q;
  logic              vsync_q2;
  logic              frame_start;
  logic              frame_done;
  logic              line_take;
  logic              pop_ok;
  logic              accept;
  logic              drop;
  logic              drain_done;
  logic [LINE_W-1:0] line_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occupancy;
  logic [PTR_W:0]    occ_nxt;
  logic              empty;
  logic              full;

  // Bank bases are elaboration-time constants, so address generation is a small mux.
  logic [ADDRESS_WIDTH-1:0] base_lut [NUM_BANKS];
  for (genvar g = 0; g < NUM_BANKS; g++) begin : gen_base
    assign base_lut[g] = ADDRESS_WIDTH'(g * WORDS_PER_LINE);
  end

  assign frame_start = vsync_q & ~vsync_q2;
  assign frame_done  = (line_cnt == LINE_LAST);
  assign line_take   = (state == ST_ACTIVE) && line_end && !frame_done && !frame_start;
  assign pop_ok      = dma_ack && !empty;
  assign accept      = line_take && (!full || pop_ok);
  assign drop        = line_take && !accept;
  assign drain_done  = (occupancy == '0) || ((occupancy == OCC_ONE) && pop_ok);

  assign dma_req  = !empty;
  assign wr_base  = base_lut[wr_ptr];
  assign dma_base = base_lut[rd_ptr];

  lbuf_bank_ring #(
    .NUM_BANKS (NUM_BANKS),
    .LINE_W    (LINE_W),
    .PTR_W     (PTR_W)
  ) u_ring (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clear     (frame_start),
    .push      (accept),
    .pop       (pop_ok),
    .push_tag  (line_cnt),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occupancy),
    .occ_nxt   (occ_nxt),
    .rd_tag    (dma_line),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = ST_ACTIVE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_ACTIVE: if (frame_done) state_nxt = ST_DRAIN;
        ST_DRAIN:  if (drain_done) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b0;
      vsync_q2  <= 1'b0;
      state     <= ST_IDLE;
      line_cnt  <= '0;
      line_irq  <= 1'b0;
      frame_irq <= 1'b0;
      overflow  <= 1'b0;
      wr_enable <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      vsync_q2  <= vsync_q;
      state     <= state_nxt;
      line_irq  <= accept;
      frame_irq <= !frame_start && (state == ST_DRAIN) && drain_done;
      wr_enable <= (state_nxt == ST_ACTIVE) && (occ_nxt < OCC_FULL);
      if (frame_start) begin
        line_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        // Dropped lines still count so the frame ends on schedule.
        if (line_take && (line_cnt != '1)) line_cnt <= line_cnt + 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

`ifdef LBUF_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [3:0]  max_occ_q;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
      max_occ_q  <= '0;
    end else if (frame_start) begin
      drop_cnt_q <= '0;
      max_occ_q  <= '0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (4'(occ_nxt) > max_occ_q) max_occ_q <= 4'(occ_nxt);
    end
  end

  assign drop_count = drop_cnt_q;
  assign max_occ    = max_occ_q;
`else
  assign drop_count = '0;
  assign max_occ    = '0;
`endif

endmodule
